// File: rtl/mandel_job_sched.sv
// Mandelbrot render-command parser and pixel job scheduler: takes a 7-byte frame from the UART,
// hands one job per tile pixel to the iteration cores and streams (cx, cy, iter) results back out.
module mandel_job_sched #(
  parameter int unsigned NCORES        = 4,
  parameter int unsigned FRAME_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_dv,
  input  logic [7:0]          rx_byte,
  output logic                tx_dv,
  output logic [7:0]          tx_byte,
  input  logic                tx_busy,
  input  logic                tx_done,
  input  logic [NCORES-1:0]   core_idle,
  output logic [NCORES-1:0]   core_start,
  output logic [15:0]         core_col,
  output logic [15:0]         core_row,
  input  logic [NCORES-1:0]   core_done,
  input  logic [8*NCORES-1:0] core_iter,
  output logic [NCORES-1:0]   core_ack,
  output logic                busy
);

  localparam int unsigned PtrW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned GapW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StOp, StArg, StRun, StEnd} state_e;

  state_e            state_q;
  logic [2:0]        arg_cnt_q;
  logic [GapW-1:0]   gap_q;
  logic [15:0]       col_start_q;
  logic [15:0]       row_start_q;
  logic [7:0]        tile_q;
  logic [7:0]        cx_q;
  logic [7:0]        cy_q;
  logic              disp_fin_q;
  logic [NCORES-1:0] inflight_q;
  logic [7:0]        job_cx_q [NCORES];
  logic [7:0]        job_cy_q [NCORES];
  logic [PtrW-1:0]   rr_q;
  logic              buf_valid_q;
  logic [1:0]        buf_idx_q;
  logic [7:0]        buf_q [3];
  logic              tx_out_q;
  logic [1:0]        end_cnt_q;

  logic              tx_dv_q;
  logic [7:0]        tx_byte_q;
  logic [NCORES-1:0] core_start_q;
  logic [15:0]       core_col_q;
  logic [15:0]       core_row_q;
  logic [NCORES-1:0] core_ack_q;

  logic              disp_found;
  logic [PtrW-1:0]   disp_idx;
  logic              grant_found;
  logic [PtrW-1:0]   grant_idx;
  logic [7:0]        grant_iter;
  logic [7:0]        tile_last;
  logic              abort;
  logic              can_dispatch;
  logic              can_grant;
  logic              run_send;
  logic              end_send;
  logic              run_done;

  always_comb begin
    int unsigned j;
    disp_found  = 1'b0;
    disp_idx    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_iter  = '0;
    j           = 0;
    // A core is eligible only if we have not already handed it a job that is still unacked
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (!disp_found && core_idle[i] && !core_done[i] && !inflight_q[i]) begin
        disp_found = 1'b1;
        disp_idx   = PtrW'(i);
      end
    end
    for (int unsigned k = 0; k < NCORES; k++) begin
      j = (32'(rr_q) + k) % NCORES;
      if (!grant_found && core_done[j]) begin
        grant_found = 1'b1;
        grant_idx   = PtrW'(j);
        grant_iter  = core_iter[8*j +: 8];
      end
    end
  end

  assign tile_last    = tile_q - 8'd1;
  assign abort        = (state_q == StRun) && rx_dv && (rx_byte == 8'h02);
  assign can_dispatch = (state_q == StRun) && !disp_fin_q && !abort && disp_found;
  assign can_grant    = (state_q == StRun) && !buf_valid_q && grant_found;
  assign run_send     = (state_q == StRun) && buf_valid_q && !tx_out_q && !tx_busy;
  assign end_send     = (state_q == StEnd) && (end_cnt_q != 2'd3) && !tx_out_q && !tx_busy;
  assign run_done     = disp_fin_q && (inflight_q == '0) && !(|core_done) && !buf_valid_q &&
                        !tx_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StOp;
      arg_cnt_q    <= '0;
      gap_q        <= '0;
      col_start_q  <= '0;
      row_start_q  <= '0;
      tile_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      disp_fin_q   <= 1'b0;
      inflight_q   <= '0;
      rr_q         <= '0;
      buf_valid_q  <= 1'b0;
      buf_idx_q    <= '0;
      tx_out_q     <= 1'b0;
      end_cnt_q    <= '0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= '0;
      core_start_q <= '0;
      core_col_q   <= '0;
      core_row_q   <= '0;
      core_ack_q   <= '0;
      for (int i = 0; i < NCORES; i++) begin
        job_cx_q[i] <= '0;
        job_cy_q[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      tx_dv_q      <= 1'b0;
      core_start_q <= '0;
      core_col_q   <= '0;
      core_row_q   <= '0;
      core_ack_q   <= '0;
      if (tx_done) begin
        tx_out_q <= 1'b0;
      end

      case (state_q)
        StOp: begin
          if (rx_dv && (rx_byte == 8'h01)) begin
            state_q   <= StArg;
            arg_cnt_q <= '0;
            gap_q     <= '0;
          end
        end

        StArg: begin
          if (rx_dv) begin
            gap_q <= '0;
            case (arg_cnt_q)
              3'd0:    col_start_q[7:0]  <= rx_byte;
              3'd1:    col_start_q[15:8] <= rx_byte;
              3'd2:    row_start_q[7:0]  <= rx_byte;
              3'd3:    row_start_q[15:8] <= rx_byte;
              3'd5:    tile_q            <= rx_byte;
              default: ;
            endcase
            arg_cnt_q <= arg_cnt_q + 3'd1;
            if (arg_cnt_q == 3'd5) begin
              state_q    <= StRun;
              cx_q       <= '0;
              cy_q       <= '0;
              disp_fin_q <= 1'b0;
            end
          end else if (gap_q == GapW'(FRAME_TIMEOUT - 1)) begin
            state_q <= StOp;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        StRun: begin
          if (abort) begin
            disp_fin_q <= 1'b1;
          end
          if (can_dispatch) begin
            core_start_q          <= NCORES'(1) << disp_idx;
            core_col_q            <= col_start_q + {8'h00, cx_q};
            core_row_q            <= row_start_q + {8'h00, cy_q};
            inflight_q[disp_idx]  <= 1'b1;
            job_cx_q[disp_idx]    <= cx_q;
            job_cy_q[disp_idx]    <= cy_q;
            // Raster order: column index runs fastest; tile byte 0 wraps to a 256-wide tile
            if (cx_q == tile_last) begin
              cx_q <= '0;
              if (cy_q == tile_last) begin
                disp_fin_q <= 1'b1;
              end else begin
                cy_q <= cy_q + 8'd1;
              end
            end else begin
              cx_q <= cx_q + 8'd1;
            end
          end
          if (can_grant) begin
            core_ack_q            <= NCORES'(1) << grant_idx;
            inflight_q[grant_idx] <= 1'b0;
            buf_q[0]              <= job_cx_q[grant_idx];
            buf_q[1]              <= job_cy_q[grant_idx];
            buf_q[2]              <= grant_iter;
            buf_valid_q           <= 1'b1;
            buf_idx_q             <= '0;
            rr_q <= (grant_idx == PtrW'(NCORES - 1)) ? '0 : grant_idx + 1'b1;
          end
          if (run_send) begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= buf_q[buf_idx_q];
            tx_out_q  <= 1'b1;
            if (buf_idx_q == 2'd2) begin
              buf_valid_q <= 1'b0;
            end else begin
              buf_idx_q <= buf_idx_q + 2'd1;
            end
          end
          if (run_done) begin
            state_q   <= StEnd;
            end_cnt_q <= '0;
          end
        end

        StEnd: begin
          if (end_send) begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= 8'hFF;
            tx_out_q  <= 1'b1;
            end_cnt_q <= end_cnt_q + 2'd1;
          end
          if (tx_done && (end_cnt_q == 2'd3)) begin
            state_q <= StOp;
          end
        end

        default: state_q <= StOp;
      endcase
    end
  end

  assign tx_dv      = tx_dv_q;
  assign tx_byte    = tx_byte_q;
  assign core_start = core_start_q;
  assign core_col   = core_col_q;
  assign core_row   = core_row_q;
  assign core_ack   = core_ack_q;
  assign busy       = (state_q == StRun) || (state_q == StEnd);

endmodule

// File: tb/tb_mandel_job_sched.sv
// Randomized bench for mandel_job_sched with behavioural iteration-core and UART models.
module tb_mandel_job_sched;
  localparam int NC = 4;
  localparam int FT = 200;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx_dv = 1'b0;
  logic [7:0]      rx_byte = 8'h00;
  logic            tx_dv;
  logic [7:0]      tx_byte;
  logic            tx_busy;
  logic            tx_done;
  logic [NC-1:0]   core_idle;
  logic [NC-1:0]   core_start;
  logic [15:0]     core_col;
  logic [15:0]     core_row;
  logic [NC-1:0]   core_done;
  logic [8*NC-1:0] core_iter;
  logic [NC-1:0]   core_ack;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic            manual = 1'b0;
  logic            force_busy = 1'b0;
  logic [NC-1:0]   m_idle = '0;
  logic [NC-1:0]   m_done = '0;
  logic [8*NC-1:0] m_iter = '0;
  logic [NC-1:0]   a_busy = '0;
  logic [NC-1:0]   a_done = '0;
  logic [8*NC-1:0] a_iter = '0;
  int              a_lat [NC];
  logic [15:0]     a_col [NC];
  logic [15:0]     a_row [NC];
  logic            u_busy = 1'b0;
  logic            u_done = 1'b0;
  int              u_cnt = 0;

  logic [7:0] txq [$];
  int         start_core [$];
  int         start_cnt = 0;
  int         n_tile = 1;
  logic [15:0] col_s = '0;
  logic [15:0] row_s = '0;
  bit         seen [65536];

  assign core_idle = manual ? m_idle : (~a_busy & ~a_done);
  assign core_done = manual ? m_done : a_done;
  assign core_iter = manual ? m_iter : a_iter;
  assign tx_busy   = u_busy | force_busy;
  assign tx_done   = u_done;

  mandel_job_sched #(.NCORES(NC), .FRAME_TIMEOUT(FT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_dv      (rx_dv),
    .rx_byte    (rx_byte),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .core_idle  (core_idle),
    .core_start (core_start),
    .core_col   (core_col),
    .core_row   (core_row),
    .core_done  (core_done),
    .core_iter  (core_iter),
    .core_ack   (core_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] iter_of(input logic [15:0] c, input logic [15:0] r);
    return c[7:0] ^ {r[3:0], r[7:4]} ^ c[15:8] ^ 8'h3C;
  endfunction

  // Model cores: busy for a random latency after a start, then hold a result until acked
  always @(negedge clk) begin
    if (!rst_n) begin
      a_busy = '0;
      a_done = '0;
    end else if (!manual) begin
      for (int i = 0; i < NC; i++) begin
        if (core_ack[i]) a_done[i] = 1'b0;
        if (core_start[i]) begin
          a_busy[i] = 1'b1;
          a_lat[i]  = int'($urandom_range(40, 5));
          a_col[i]  = core_col;
          a_row[i]  = core_row;
        end else if (a_busy[i]) begin
          a_lat[i]--;
          if (a_lat[i] == 0) begin
            a_busy[i] = 1'b0;
            a_done[i] = 1'b1;
            a_iter[8*i +: 8] = iter_of(a_col[i], a_row[i]);
          end
        end
      end
    end
  end

  // Dispatch and ack monitor: jobs must leave in raster order of the current frame
  always @(negedge clk) begin
    if (rst_n) begin
      if (|core_start) begin
        check("start_onehot", 32'($onehot(core_start)), 32'd1);
        check("start_while_done", 32'(core_start & core_done), 32'd0);
        if (start_cnt < n_tile * n_tile)
          check("start_pixel", {core_col, core_row},
                {col_s + 16'(start_cnt % n_tile), row_s + 16'(start_cnt / n_tile)});
        else
          check("extra_start", 32'(start_cnt), 32'(n_tile * n_tile));
        for (int i = 0; i < NC; i++) if (core_start[i]) start_core.push_back(i);
        start_cnt++;
      end
      if (|core_ack) check("ack_onehot", 32'($onehot(core_ack)), 32'd1);
    end
  end

  // UART transmitter model
  always @(negedge clk) begin
    if (!rst_n) begin
      u_busy = 1'b0;
      u_done = 1'b0;
    end else begin
      u_done = 1'b0;
      if (tx_dv) begin
        check("tx_dv_while_busy", 32'(u_busy | force_busy), 32'd0);
        txq.push_back(tx_byte);
        u_busy = 1'b1;
        u_cnt  = int'($urandom_range(6, 2));
      end else if (u_busy) begin
        u_cnt--;
        if (u_cnt == 0) begin
          u_busy = 1'b0;
          u_done = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv = 1'b0;
    tick();
  endtask

  task automatic send_frame(input logic [15:0] c, input logic [15:0] r, input logic [7:0] t);
    col_s     = c;
    row_s     = r;
    n_tile    = (t == 8'h00) ? 256 : int'(t);
    start_cnt = 0;
    start_core.delete();
    txq.delete();
    send_byte(8'h01);
    send_byte(c[7:0]);
    send_byte(c[15:8]);
    send_byte(r[7:0]);
    send_byte(r[15:8]);
    send_byte(8'($urandom));
    send_byte(t);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int t = 0;
    while (busy && t < limit) begin
      tick();
      t++;
    end
    check(tag, 32'(busy), 32'd0);
    repeat (4) tick();
  endtask

  task automatic wait_starts(input int target, input int limit);
    int t = 0;
    while (start_cnt < target && t < limit) begin
      tick();
      t++;
    end
    check("starts_reached", 32'(start_cnt), 32'(target));
  endtask

  task automatic ack_wait(input int exp_core);
    int t = 0;
    int got = -1;
    do begin
      tick();
      t++;
    end while (!(|core_ack) && t < 300);
    for (int i = 0; i < NC; i++) if (core_ack[i]) got = i;
    check("ack_core", 32'(got), 32'(exp_core));
    if (got >= 0) m_done[got] = 1'b0;
  endtask

  // Every result must be a distinct, already-dispatched tile pixel with the core's iter value
  task automatic check_frame(input int exp_pix);
    int nb;
    int np;
    int key;
    logic [7:0] cx, cy, it;
    bit ok;
    foreach (seen[i]) seen[i] = 1'b0;
    nb = txq.size();
    check("byte_count", 32'(nb), 32'(3 * exp_pix + 3));
    if (nb >= 3) check("end_marker", {8'h00, txq[nb-3], txq[nb-2], txq[nb-1]}, 32'h00FF_FFFF);
    np = (nb >= 3) ? (nb - 3) / 3 : 0;
    for (int p = 0; p < np; p++) begin
      cx  = txq[3*p];
      cy  = txq[3*p+1];
      it  = txq[3*p+2];
      key = int'(cy) * 256 + int'(cx);
      ok  = (int'(cx) < n_tile) && (int'(cy) < n_tile) && !seen[key] &&
            (int'(cy) * n_tile + int'(cx) < start_cnt);
      seen[key] = 1'b1;
      check("triple", {23'b0, ok, it}, {23'b0, 1'b1, iter_of(col_s + 16'(cx), row_s + 16'(cy))});
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_colrow"}, {core_col, core_row}, 32'd0);
    check({tag, "_ctrl"}, {14'b0, tx_dv, tx_byte, core_start, core_ack, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] exp4 [18];
    int seen_start;

    rst_n = 1'b0;
    repeat (3) tick();
    check_outs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Full 16x16 tile at a random origin
    send_frame(16'($urandom), 16'($urandom), 8'h10);
    check("busy_rise", 32'(busy), 32'd1);
    wait_idle("t1_done", 30000);
    check("t1_starts", 32'(start_cnt), 32'd256);
    check_frame(256);

    // 256-wide tile: raster order with column wrap past 0xFFFF, then abort
    send_frame(16'hFFF0, 16'h1234, 8'h00);
    wait_starts(20, 3000);
    send_byte(8'h02);
    wait_idle("t2_done", 3000);
    check("t2_starts", 32'(start_cnt), 32'd20);
    check_frame(20);

    // Partial frame dropped by the inter-byte timeout
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h00);
    repeat (FT + 20) tick();
    check("timeout_idle", 32'(busy), 32'd0);
    send_frame(16'h0000, 16'h0000, 8'h02);
    wait_idle("t3_done", 3000);
    check("t3_starts", 32'(start_cnt), 32'd4);
    check_frame(4);

    // Round-robin: after core 1 is served, simultaneous results drain as 2,3,0,1
    manual = 1'b1;
    m_done = '0;
    m_iter = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    m_idle = 4'b0011;
    send_frame(16'h0000, 16'h0000, 8'h03);
    wait_starts(2, 50);
    repeat (10) tick();
    m_idle = '0;
    check("t4_pair", 32'(start_cnt), 32'd2);
    m_done = 4'b0010;
    ack_wait(1);
    m_idle = 4'b1110;
    wait_starts(5, 50);
    repeat (10) tick();
    m_idle = '0;
    check("t4_five", 32'(start_cnt), 32'd5);
    m_done = 4'b1111;
    ack_wait(2);
    ack_wait(3);
    ack_wait(0);
    ack_wait(1);
    send_byte(8'h02);
    wait_idle("t4_done", 3000);
    exp4 = '{8'h01, 8'h00, 8'hA1, 8'h00, 8'h01, 8'hA2, 8'h01, 8'h01, 8'hA3,
             8'h00, 8'h00, 8'hA0, 8'h02, 8'h00, 8'hA1, 8'hFF, 8'hFF, 8'hFF};
    check("t4_bytes", 32'(txq.size()), 32'd18);
    for (int i = 0; i < 18 && i < txq.size(); i++) check("t4_byte", 32'(txq[i]), 32'(exp4[i]));
    check("t4_cores", 32'(start_core.size()), 32'd5);
    if (start_core.size() == 5)
      check("t4_core_seq", {start_core[0][3:0], start_core[1][3:0], start_core[2][3:0],
                            start_core[3][3:0], start_core[4][3:0]}, 32'h00001123);
    manual = 1'b0;
    m_done = '0;

    // Abort after 10 dispatches; junk byte in RUN ignored
    send_frame(16'($urandom), 16'($urandom), 8'h08);
    wait_starts(10, 3000);
    send_byte(8'h02);
    send_byte(8'h55);
    wait_idle("t5_done", 3000);
    check("t5_starts", 32'(start_cnt), 32'd10);
    check_frame(10);

    // Result pending while the transmitter reports busy, then reset mid-dispatch
    manual     = 1'b1;
    m_done     = '0;
    m_idle     = 4'b0001;
    force_busy = 1'b1;
    send_frame(16'h0000, 16'h0000, 8'h02);
    wait_starts(1, 50);
    m_idle = '0;
    m_iter[7:0] = 8'h77;
    m_done = 4'b0001;
    ack_wait(0);
    repeat (500) tick();
    check("t6_held", 32'(txq.size()), 32'd0);
    force_busy = 1'b0;
    repeat (60) tick();
    check("t6_sent", 32'(txq.size()), 32'd3);
    if (txq.size() == 3) check("t6_triple", {8'h00, txq[0], txq[1], txq[2]}, 32'h0000_0077);
    check("t6_busy_mid", 32'(busy), 32'd1);
    m_idle = 4'b1110;
    seen_start = 0;
    for (int t = 0; t < 50 && seen_start == 0; t++) begin
      @(negedge clk);
      if (|core_start) seen_start = 1;
    end
    check("t6_start_seen", 32'(seen_start), 32'd1);
    rst_n = 1'b0;
    #1;
    check_outs_zero("t6_reset");
    m_idle = '0;
    m_done = '0;
    manual = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_after", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
